// File: rtl/mem_wb_pkg.sv
// Types and constants shared by the MEM/WB stage and its writeback select.
package mem_wb_pkg;

    localparam int unsigned XLEN = 32;

    // Writeback source; 2'b11 is not named and falls back to the ALU result.
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_LD  = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    // Contents of the MEM/WB pipeline register.
    typedef struct packed {
        logic            vld;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] alu;
        logic [4:0]      rd;
        logic            rd_wren;
        logic [1:0]      wb_sel;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_wb_mux.sv
// Combinational writeback-data select for the WB stage.
module wb_mux
    import mem_wb_pkg::*;
(
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] ld_data,
    input  logic [XLEN-1:0] alu,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] data
);

    // Pick the register-file write value; pc+4 wraps modulo 2^XLEN.
    always_comb begin
        data = alu;
        unique case (sel)
            WB_LD:   data = ld_data;
            WB_PC4:  data = pc + XLEN'(4);
            default: data = alu;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, load-data hold, retire pulse and instret counter.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int unsigned INSTRET_W = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic                 i_vld,
    input  logic [XLEN-1:0]      i_pc,
    input  logic [31:0]          i_instr,
    input  logic [XLEN-1:0]      i_alu_data,
    input  logic [XLEN-1:0]      i_ld_data,
    input  logic [4:0]           i_rd_addr,
    input  logic                 i_rd_wren,
    input  logic [1:0]           i_wb_sel,
    output logic [4:0]           o_rd_addr,
    output logic                 o_rd_wren,
    output logic [XLEN-1:0]      o_wb_data,
    output logic                 o_insn_vld,
    output logic [XLEN-1:0]      o_pc_debug,
    output logic [31:0]          o_instr,
    output logic [INSTRET_W-1:0] o_instret
);

    mem_wb_t               wb;
    mem_wb_t               mem_in;
    logic [XLEN-1:0]       ld_hold;
    logic                  hold_vld;
    logic                  done;
    logic [INSTRET_W-1:0]  instret;
    logic [XLEN-1:0]       ld_sel;
    logic                  insn_vld;

    // Pack the MEM-stage inputs into the register format.
    always_comb begin
        mem_in         = '0;
        mem_in.vld     = i_vld;
        mem_in.pc      = i_pc;
        mem_in.instr   = i_instr;
        mem_in.alu     = i_alu_data;
        mem_in.rd      = i_rd_addr;
        mem_in.rd_wren = i_rd_wren;
        mem_in.wb_sel  = i_wb_sel;
    end

    // WB register with load-data freeze; done marks an already-retired stalled instruction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wb       <= '0;
            ld_hold  <= '0;
            hold_vld <= 1'b0;
            done     <= 1'b0;
        end else if (i_flush) begin
            wb       <= '0;
            hold_vld <= 1'b0;
            done     <= 1'b0;
        end else if (i_stall) begin
            // LSU data may change once MEM moves on, so capture it on the first stalled edge.
            if (!hold_vld) begin
                ld_hold  <= i_ld_data;
                hold_vld <= 1'b1;
            end
            if (wb.vld) begin
                done <= 1'b1;
            end
        end else begin
            wb       <= mem_in;
            hold_vld <= 1'b0;
            done     <= 1'b0;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            instret <= '0;
        end else if (insn_vld) begin
            instret <= instret + INSTRET_W'(1);
        end
    end

    // Load data comes from the hold register once a stall has frozen it.
    always_comb begin
        ld_sel = hold_vld ? ld_hold : i_ld_data;
    end

    wb_mux u_wb_mux (
        .sel     (wb.wb_sel),
        .ld_data (ld_sel),
        .alu     (wb.alu),
        .pc      (wb.pc),
        .data    (o_wb_data)
    );

    // Retire and write exactly once, in the first WB cycle; x0 is never written.
    always_comb begin
        insn_vld   = wb.vld & ~done;
        o_insn_vld = insn_vld;
        o_rd_wren  = insn_vld & wb.rd_wren & (wb.rd != 5'd0);
        o_rd_addr  = wb.rd;
        o_pc_debug = wb.pc;
        o_instr    = wb.instr;
        o_instret  = instret;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu_data;
    logic [31:0] ld_data;
    logic [4:0]  rd_addr;
    logic        rd_wren;
    logic [1:0]  wb_sel;

    logic [4:0]  o_rd_addr;
    logic        o_rd_wren;
    logic [31:0] o_wb_data;
    logic        o_insn_vld;
    logic [31:0] o_pc_debug;
    logic [31:0] o_instr;
    logic [63:0] o_instret;

    int checks = 0;
    int errors = 0;

    mem_wb_stage #(.INSTRET_W(64)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_stall    (stall),
        .i_flush    (flush),
        .i_vld      (vld),
        .i_pc       (pc),
        .i_instr    (instr),
        .i_alu_data (alu_data),
        .i_ld_data  (ld_data),
        .i_rd_addr  (rd_addr),
        .i_rd_wren  (rd_wren),
        .i_wb_sel   (wb_sel),
        .o_rd_addr  (o_rd_addr),
        .o_rd_wren  (o_rd_wren),
        .o_wb_data  (o_wb_data),
        .o_insn_vld (o_insn_vld),
        .o_pc_debug (o_pc_debug),
        .o_instr    (o_instr),
        .o_instret  (o_instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_insn(input logic v, input logic [31:0] p, input logic [31:0] a,
                            input logic [4:0] r, input logic w, input logic [1:0] s);
        vld      = v;
        pc       = p;
        instr    = p ^ 32'h0000_0013;
        alu_data = a;
        rd_addr  = r;
        rd_wren  = w;
        wb_sel   = s;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        ld_data = '0;
        set_insn(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);

        // Reset state
        #12;
        chk("rst_wren", 64'(o_rd_wren), 64'h0);
        chk("rst_insn_vld", 64'(o_insn_vld), 64'h0);
        chk("rst_instret", o_instret, 64'h0);
        chk("rst_wb_data", 64'(o_wb_data), 64'h0);
        #10 rst_n = 1'b1;
        step();

        // ALU write
        set_insn(1'b1, 32'h40, 32'h1234, 5'd5, 1'b1, 2'b00);
        step();
        chk("alu_wren", 64'(o_rd_wren), 64'h1);
        chk("alu_addr", 64'(o_rd_addr), 64'h5);
        chk("alu_data", 64'(o_wb_data), 64'h1234);
        chk("alu_insn_vld", 64'(o_insn_vld), 64'h1);
        chk("alu_pc", 64'(o_pc_debug), 64'h40);
        chk("alu_instr", 64'(o_instr), 64'h53);
        vld = 1'b0;
        step();
        chk("alu_pulse_end", 64'(o_insn_vld), 64'h0);
        chk("alu_instret", o_instret, 64'h1);

        // Load with 3-cycle stall; data must freeze
        set_insn(1'b1, 32'h80, 32'h2000, 5'd7, 1'b1, 2'b01);
        step();
        vld = 1'b0;
        stall = 1'b1;
        ld_data = 32'hDEAD_BEEF;
        #1;
        chk("ld_data_first", 64'(o_wb_data), 64'hDEAD_BEEF);
        chk("ld_wren_first", 64'(o_rd_wren), 64'h1);
        chk("ld_vld_first", 64'(o_insn_vld), 64'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            ld_data = 32'h0;
            #1;
            chk("ld_data_held", 64'(o_wb_data), 64'hDEAD_BEEF);
            chk("ld_wren_held", 64'(o_rd_wren), 64'h0);
            chk("ld_vld_held", 64'(o_insn_vld), 64'h0);
            chk("ld_instret", o_instret, 64'h2);
        end
        stall = 1'b0;
        step();
        chk("ld_after_instret", o_instret, 64'h2);

        // JAL link, including wrap
        set_insn(1'b1, 32'h100, 32'h0, 5'd1, 1'b1, 2'b10);
        step();
        chk("jal_data", 64'(o_wb_data), 64'h104);
        set_insn(1'b1, 32'hFFFF_FFFC, 32'h0, 5'd1, 1'b1, 2'b10);
        step();
        chk("jal_wrap_data", 64'(o_wb_data), 64'h0);
        chk("jal_wrap_wren", 64'(o_rd_wren), 64'h1);
        vld = 1'b0;
        step();
        chk("jal_instret", o_instret, 64'h4);

        // wb_sel 11 behaves as ALU
        set_insn(1'b1, 32'h180, 32'hA5A5_0001, 5'd4, 1'b1, 2'b11);
        step();
        chk("sel11_data", 64'(o_wb_data), 64'hA5A5_0001);

        // x0 suppression
        set_insn(1'b1, 32'h1C0, 32'h55, 5'd0, 1'b1, 2'b00);
        step();
        chk("x0_wren", 64'(o_rd_wren), 64'h0);
        chk("x0_insn_vld", 64'(o_insn_vld), 64'h1);
        vld = 1'b0;
        step();
        chk("x0_instret", o_instret, 64'h6);

        // Flush beats stall
        set_insn(1'b1, 32'h200, 32'h77, 5'd3, 1'b1, 2'b00);
        step();
        set_insn(1'b1, 32'h204, 32'h88, 5'd6, 1'b1, 2'b00);
        flush = 1'b1;
        stall = 1'b1;
        step();
        chk("flush_insn_vld", 64'(o_insn_vld), 64'h0);
        chk("flush_wren", 64'(o_rd_wren), 64'h0);
        chk("flush_rd", 64'(o_rd_addr), 64'h0);
        chk("flush_pc", 64'(o_pc_debug), 64'h0);
        chk("flush_instret", o_instret, 64'h7);
        flush = 1'b0;
        stall = 1'b0;
        vld = 1'b0;
        step();
        chk("flush_instret_hold", o_instret, 64'h7);

        // Async reset mid-stall
        set_insn(1'b1, 32'h300, 32'h0, 5'd9, 1'b1, 2'b01);
        step();
        vld = 1'b0;
        stall = 1'b1;
        ld_data = 32'hCAFE_F00D;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wb_data", 64'(o_wb_data), 64'h0);
        chk("arst_rd", 64'(o_rd_addr), 64'h0);
        chk("arst_pc", 64'(o_pc_debug), 64'h0);
        chk("arst_instret", o_instret, 64'h0);
        chk("arst_insn_vld", 64'(o_insn_vld), 64'h0);
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // Hold discarded: live load data must be used
        set_insn(1'b1, 32'h400, 32'h0, 5'd10, 1'b1, 2'b01);
        ld_data = 32'h11;
        step();
        chk("post_rst_ld", 64'(o_wb_data), 64'h11);
        vld = 1'b0;
        step();
        chk("post_rst_instret", o_instret, 64'h1);

        // instret wrap
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret;
        #1;
        chk("wrap_preload", o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
        set_insn(1'b1, 32'h500, 32'h1, 5'd2, 1'b1, 2'b00);
        step();
        chk("wrap_insn_vld", 64'(o_insn_vld), 64'h1);
        vld = 1'b0;
        step();
        chk("wrap_instret", o_instret, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
